// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor finishes in one cycle without iterating.
module seq_divider #(
  parameter int DATA_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] dividend,
  input  logic [DATA_SIZE-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_SIZE-1:0] quotient,
  output logic [DATA_SIZE-1:0] remainder,
  output logic                 div_by_zero
);

  localparam int CW = (DATA_SIZE > 2) ? $clog2(DATA_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] rem_q, rem_d;
  logic [DATA_SIZE-1:0] sh_q, sh_d;
  logic [DATA_SIZE-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] quot_q, quot_d;
  logic [DATA_SIZE-1:0] remo_q, remo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  // The stored partial remainder never exceeds divisor-1, so its top bit is
  // always 0; only the trial subtraction needs the extra bit.
  logic [DATA_SIZE:0]   shifted, diff;
  logic [DATA_SIZE-1:0] rem_nx, sh_nx;

  always_comb begin
    shifted = {rem_q, sh_q[DATA_SIZE-1]};
    diff    = shifted - {1'b0, dvsr_q};
    if (!diff[DATA_SIZE]) begin
      rem_nx = diff[DATA_SIZE-1:0];
      sh_nx  = {sh_q[DATA_SIZE-2:0], 1'b1};
    end else begin
      rem_nx = shifted[DATA_SIZE-1:0];
      sh_nx  = {sh_q[DATA_SIZE-2:0], 1'b0};
    end

    state_d = state_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    case (state_q)
      S_RUN: begin
        rem_d = rem_nx;
        sh_d  = sh_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quot_d  = sh_nx;
          remo_d  = rem_nx;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          dvsr_d  = divisor;
          sh_d    = dividend;
          rem_d   = '0;
          cnt_d   = '0;
          dbz_d   = (divisor == '0);
          state_d = S_RUN;
          busy_d  = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          if (divisor == '0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            quot_d  = '1;
            remo_d  = dividend;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      sh_q    <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed test-plan cases plus randomized
// operands checked against plain integer division.
module tb_seq_divider;
  localparam int N = 16;
`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start;
  logic [N-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [N-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  seq_divider #(.DATA_SIZE(N)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [N-1:0] b);
    return (FAST && b == '0) ? 1 : N + 1;
  endfunction

  // Start in cycle 0, then watch up to 40 cycles for done.
  task automatic run_op(input logic [N-1:0] a, b, output int lat, output int bcnt,
                        output logic [N-1:0] q, r, output logic z, output bit ovl);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    lat = -1; bcnt = 0; q = '0; r = '0; z = 1'b0; ovl = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
      if (busy && done) ovl = 1'b1;
      if (done) begin
        lat = c; q = quotient; r = remainder; z = div_by_zero;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_err++;
      $display("FAIL reset: got busy=%b done=%b dbz=%b q=%h r=%h want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst = 1'b0;
  endtask

  task automatic check_op(input string nm, input logic [N-1:0] a, b);
    int lat, bcnt; logic [N-1:0] q, r, eq, er; logic z; bit ovl;
    eq = (b == '0) ? '1 : a / b;
    er = (b == '0) ? a : a % b;
    run_op(a, b, lat, bcnt, q, r, z, ovl);
    n_cmp++;
    if (lat != exp_lat(b) || bcnt != exp_lat(b) - 1 || ovl) begin
      n_err++;
      $display("FAIL %s timing: got lat=%0d busy_cycles=%0d overlap=%0b want lat=%0d busy_cycles=%0d overlap=0",
               nm, lat, bcnt, ovl, exp_lat(b), exp_lat(b) - 1);
    end
    n_cmp++;
    if (q !== eq || r !== er || z !== (b == '0)) begin
      n_err++;
      $display("FAIL %s result: %0d/%0d got q=%h r=%h z=%b want q=%h r=%h z=%b",
               nm, a, b, q, r, z, eq, er, (b == '0));
    end
    // done must drop after one cycle while results stay put
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || quotient !== eq || remainder !== er) begin
      n_err++;
      $display("FAIL %s hold: got done=%b q=%h r=%h want done=0 q=%h r=%h",
               nm, done, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_basic;
    check_op("d100_7", 16'd100, 16'd7);
    check_op("dffff_1", 16'hFFFF, 16'd1);
    check_op("d5_9", 16'd5, 16'd9);
  endtask

  task automatic test_div_zero;
    check_op("dzero", 16'h1234, 16'd0);
  endtask

  task automatic test_back_to_back;
    int d1 = -1, d2 = -1; bit b18 = 1'b0;
    logic [N-1:0] q1 = '0, r1 = '0, q2 = '0, r2 = '0;
    @(negedge clk);
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done && d1 < 0) begin d1 = c; q1 = quotient; r1 = remainder; end
      else if (done && d2 < 0) begin d2 = c; q2 = quotient; r2 = remainder; end
      if (c == 18) b18 = busy;
      if (c == 5 || c == 17) begin
        dividend = 16'd50; divisor = 16'd5; start = 1'b1;
      end
      if (d2 >= 0) break;
    end
    start = 1'b0;
    n_cmp++;
    if (d1 != 17 || q1 !== 16'd14 || r1 !== 16'd2) begin
      n_err++;
      $display("FAIL b2b_first: got done@%0d q=%0d r=%0d want done@17 q=14 r=2", d1, q1, r1);
    end
    n_cmp++;
    if (b18 !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_busy18: got busy=%b want 1", b18);
    end
    n_cmp++;
    if (d2 != 34 || q2 !== 16'd10 || r2 !== 16'd0) begin
      n_err++;
      $display("FAIL b2b_second: got done@%0d q=%0d r=%0d want done@34 q=10 r=0", d2, q2, r2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int ndone = 0;
    @(negedge clk);
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 8) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, quotient, remainder} !== '0) begin
      n_err++;
      $display("FAIL rst_mid: got busy=%b done=%b q=%h r=%h want all 0", busy, done, quotient, remainder);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_err++;
      $display("FAIL rst_mid_quiet: got %0d busy/done cycles want 0", ndone);
    end
    check_op("after_rst", 16'd37, 16'd6);
  endtask

  task automatic test_random;
    logic [N-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = N'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1, 2:    b = N'($urandom_range(1, 15));
        3:       b = N'($urandom_range(1, 255));
        default: b = N'($urandom);
      endcase
      check_op("random", a, b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_div_zero;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
